// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and defaults for the interrupt controller
package irq_pkg;

   localparam int NUM_SRC_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-wins priority encoder
module irq_prio_enc #(
   parameter int N    = 8,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   output logic [ID_W-1:0] id,
   output logic            valid
);

   // scan from the top down so the lowest set index is the last to overwrite id
   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            id    = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - pending/mask latch and one-at-a-time CPU interrupt handshake
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEFAULT,
   parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] mask_q,
   output logic [NUM_SRC-1:0] pending_q,
   output logic               cpu_irq,
   output logic [ID_W-1:0]    cpu_irq_id,
   input  logic               cpu_ack,
   input  logic               cpu_eoi
);

   irq_state_e         state;
   logic [NUM_SRC-1:0] candidate;
   logic [NUM_SRC-1:0] ack_clr;
   logic [ID_W-1:0]    win_id;
   logic               win_valid;
   logic               ack_take;

   assign candidate = pending_q & mask_q;
   assign ack_take  = (state == ST_REQ) && cpu_ack;

   irq_prio_enc #(
      .N    (NUM_SRC),
      .ID_W (ID_W)
   ) u_prio_enc (
      .req   (candidate),
      .id    (win_id),
      .valid (win_valid)
   );

   // one-hot clear of the pending bit belonging to the acknowledged request
   always_comb begin
      ack_clr = '0;
      if (ack_take) begin
         ack_clr[cpu_irq_id] = 1'b1;
      end
   end

   // enable mask register, written whole on each strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '0;
      end else if (mask_we) begin
         mask_q <= mask_wdata;
      end
   end

   // pending latch: a new pulse beats an ack clear landing in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= (pending_q & ~ack_clr) | src_irq;
      end
   end

   // request/ack/eoi handshake with registered cpu_irq and cpu_irq_id
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cpu_irq    <= 1'b0;
         cpu_irq_id <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  cpu_irq_id <= win_id;
                  cpu_irq    <= 1'b1;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               // ack is checked first so it wins over a same-cycle mask-off
               if (cpu_ack) begin
                  cpu_irq <= 1'b0;
                  state   <= ST_SERVICE;
               end else if (!mask_q[cpu_irq_id]) begin
                  cpu_irq <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            ST_SERVICE: begin
               cpu_irq <= 1'b0;
               if (cpu_eoi) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               cpu_irq <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that receives single-cycle interrupt pulses from peripheral sources (the free-running timer on source 0, others on higher indices) and delivers them to the CPU one at a time. It latches each pulse into a pending bit, masks it, picks the highest-priority enabled source, and runs a request/acknowledge/end-of-interrupt handshake with the CPU core. It sits between the peripheral irq outputs and the CPU's interrupt input.

## Interface
- NUM_SRC, 8: number of interrupt sources; index 0 is highest priority.
- ID_W, $clog2(NUM_SRC): width of the source ID.

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- src_irq  in  NUM_SRC  per-source pulse inputs; a cycle with the bit high is one event.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  NUM_SRC  new enable mask; 1 = enabled.
- mask_q  out  NUM_SRC  current enable mask.
- pending_q  out  NUM_SRC  current pending bits.
- cpu_irq  out  1  interrupt request to CPU.
- cpu_irq_id  out  ID_W  ID of requested source; valid while cpu_irq=1.
- cpu_ack  in  1  CPU accepts the presented request.
- cpu_eoi  in  1  CPU finished servicing; controller may issue the next request.

## Operation
- Reset values: mask_q=0, pending_q=0, cpu_irq=0, cpu_irq_id=0, state IDLE.
- Pending: pending[i] sets on any clock where src_irq[i]=1. Repeated pulses while set merge, with no counting. pending[i] clears only on cpu_ack for ID i. If a set and a clear coincide, the set wins.
- Mask: on mask_we, mask_q <= mask_wdata. Masking does not clear pending bits.
- Candidate: pending_q & mask_q. The lowest set index wins.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if candidate is non-zero, latch the winning ID into cpu_irq_id, set cpu_irq=1, and go to REQ.
  - REQ: cpu_irq_id stays stable. On cpu_ack, clear pending[cpu_irq_id], drop cpu_irq, and go to SERVICE. If mask_q[cpu_irq_id] is 0 and there is no ack, withdraw: drop cpu_irq and go to IDLE. Ack takes priority over withdrawal in the same cycle.
  - SERVICE: cpu_irq=0. On cpu_eoi, go to IDLE. No nesting.
- cpu_ack outside REQ is ignored. cpu_eoi outside SERVICE is ignored.
- A higher-priority source arriving during REQ does not preempt; it is arbitrated at the next IDLE.
- Reset mid-handshake returns immediately to the reset values. The in-flight event is lost.

## Timing
- src_irq[i] high at cycle t: pending[i]=1 at t+1. If enabled and the FSM is IDLE, cpu_irq=1 with its ID at t+2.
- cpu_ack at cycle a: cpu_irq=0 and pending bit clear at a+1.
- cpu_eoi at cycle e: IDLE at e+1. Earliest next cpu_irq is e+2.
- mask_we at cycle m: the new mask affects arbitration and withdrawal from m+1.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package irq_pkg holds the FSM state enum (IDLE, REQ, SERVICE) and the default NUM_SRC constant.
- Sub-module irq_prio_enc is a combinational lowest-index-wins encoder, NUM_SRC wide. Its outputs are a one-hot-to-ID result plus a valid flag.
- The top level holds the pending/mask registers, the FSM and the ID register.

## Test plan
- Reset, then mask=8'h01, then a src_irq[0] pulse at cycle 10: cpu_irq=1 and ID=0 at cycle 12. Ack at 15 gives cpu_irq=0 and pending=0 at 16. EOI at 18 leaves cpu_irq=0 through 20.
- mask=8'hFF, with src_irq=8'b1010_0000 in one cycle: ID=5 first. After ack+EOI, ID=7 is issued 2 cycles after EOI, then pending_q=0.
- Pulse src_irq[2] with mask=0: pending_q=8'h04 and cpu_irq stays 0. Set mask=8'h04: cpu_irq=1 with ID=2 two cycles after mask_we.
- In REQ for ID 3, clear mask bit 3 with no ack: cpu_irq drops next cycle, pending[3] stays 1, state is IDLE.
- In REQ for ID 1, pulse src_irq[1] in the same cycle as cpu_ack: pending[1] remains 1. After EOI, ID 1 is requested again.
- Assert rst while in SERVICE with pending=8'h06: all outputs and mask/pending are 0 immediately. A later EOI is ignored.
